npu_requant_pool2: RTL and testbench

// - Post-convolution stage between the NPU accumulator output and the next layer's ifmap memory.
// - Takes one signed accumulator per beat, raster order, one ofmap plane of IN_W x IN_H pixels.
// - Requantizes each value: arithmetic shift, ReLU, saturate to N-bit unsigned.
// - Applies 2x2/stride-2 max-pooling (e.g. 28x28 C1 output -> 14x14 for the IMG2 layer).

---
 rtl/npu_requant_pool2.sv | 151 +++++++++++++++
 tb/tb_npu_requant_pool2.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/npu_requant_pool2.sv
// Requantize signed accumulators (shift, ReLU, saturate to N bits), then 2x2 stride-2 max-pool
// one raster-order plane. Define NPU_POOL_ROUND_EN to get round-half-up before the shift.
module npu_requant_pool2 #(
    parameter int N     = 4,
    parameter int ACC_W = 16,
    parameter int IN_W  = 28,
    parameter int IN_H  = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       shift_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [ACC_W-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N-1:0]     out_data_o,
    output logic             frame_done_o,
    output logic             busy_o
);
    localparam int CW  = $clog2(IN_W);
    localparam int RW  = $clog2(IN_H);
    localparam int HW  = IN_W / 2;
    localparam int HIW = (HW > 1) ? $clog2(HW) : 1;
    localparam logic [CW-1:0]  COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(IN_H - 1);
    localparam logic [ACC_W:0] Q_MAX    = (ACC_W+1)'((1 << N) - 1);

    if (IN_W % 2 != 0) begin : g_chk_w
        $error("npu_requant_pool2: IN_W must be even");
    end
    if (IN_H % 2 != 0) begin : g_chk_h
        $error("npu_requant_pool2: IN_H must be even");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_frame_done, w_done_nxt;
    logic [3:0]      r_shift;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [N-1:0]    r_hold;
    logic            r_out_valid;
    logic [N-1:0]    r_out_data;
    logic [N-1:0]    r_lbuf [HW];

    logic            w_in_acc, w_out_hs, w_last_beat;
    logic [HIW-1:0]  w_half;
    logic [ACC_W:0]  w_mag;
    logic [N-1:0]    w_q, w_pair, w_pool;

    assign in_ready_o   = (r_state == S_RUN) && (!r_out_valid || out_ready_i);
    assign w_in_acc     = in_valid_i && in_ready_o;
    assign w_out_hs     = r_out_valid && out_ready_i;
    assign w_last_beat  = (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_half       = HIW'(r_col >> 1);
    assign out_valid_o  = r_out_valid;
    assign out_data_o   = r_out_data;
    assign frame_done_o = r_frame_done;
    assign busy_o       = (r_state != S_IDLE);

    // Negative inputs never reach the shifter, so a logical shift of the magnitude is exact.
    always_comb begin
        w_mag = '0;
        w_q   = '0;
        if (!in_data_i[ACC_W-1]) begin
            w_mag = {1'b0, in_data_i};
`ifdef NPU_POOL_ROUND_EN
            if (r_shift != 4'd0) begin
                w_mag = w_mag + ((ACC_W+1)'(1) << (r_shift - 4'd1));
            end
`endif
            w_mag = w_mag >> r_shift;
            w_q   = (w_mag > Q_MAX) ? {N{1'b1}} : w_mag[N-1:0];
        end
    end

    assign w_pair = (r_hold > w_q) ? r_hold : w_q;
    assign w_pool = (r_lbuf[w_half] > w_pair) ? r_lbuf[w_half] : w_pair;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (start_i) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_RUN:   if (w_in_acc && w_last_beat) w_state_nxt = S_FLUSH;
                S_FLUSH: if (w_out_hs) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (start_i) begin
            r_shift     <= shift_i;
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_out_hs) r_out_valid <= 1'b0;
            if (w_in_acc) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                // A new odd/odd beat overrides the clear from a same-cycle output handshake.
                if (!r_col[0]) begin
                    r_hold <= w_q;
                end else if (r_row[0]) begin
                    r_out_data  <= w_pool;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_acc && r_col[0] && !r_row[0]) r_lbuf[w_half] <= w_pair;
    end
endmodule

// File: tb/tb_npu_requant_pool2.sv
// Bench for npu_requant_pool2: uniform-plane vector table, hand-built block ordering plane,
// back-pressure, abort and random planes against an arithmetic reference model.
module tb_npu_requant_pool2;
  localparam int W = 28;
  localparam int H = 28;
  localparam int NB = W * H;
  localparam int NO = (W / 2) * (H / 2);
  localparam int BUDGET = 20000;
`ifdef NPU_POOL_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic start_i;
  logic [3:0] shift_i;
  logic in_valid_i;
  logic in_ready_o;
  logic [15:0] in_data_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [3:0] out_data_o;
  logic frame_done_o;
  logic busy_o;

  npu_requant_pool2 dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .shift_i(shift_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int shift;
    int val;
    int exp;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic signed [15:0] beats [NB];
  logic [3:0] exp_q [$];
  logic [3:0] got_q [$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // reference model: requant each pixel, then max over each 2x2 block in raster block order
  function automatic int qf(input int x, input int s);
    int y;
    if (x < 0) return 0;
    if (RND && s > 0) y = (x + (1 << (s - 1))) >> s;
    else y = x >> s;
    return (y > 15) ? 15 : y;
  endfunction

  task automatic fill_model(input int s);
    int m;
    exp_q.delete();
    for (int br = 0; br < H / 2; br++) begin
      for (int bc = 0; bc < W / 2; bc++) begin
        m = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (qf(int'(beats[(2*br+dr)*W + 2*bc+dc]), s) > m)
              m = qf(int'(beats[(2*br+dr)*W + 2*bc+dc]), s);
        exp_q.push_back(4'(m));
      end
    end
  endtask

  task automatic rand_beats(input int lo, input int hi);
    for (int p = 0; p < NB; p++) beats[p] = 16'($urandom_range(0, hi - lo) + lo);
  endtask

  // driver + scoreboard: mode 0 = always valid/ready, 1 = random gaps, 2 = 10-cycle stall at first output
  task automatic run_plane(input int s, input int mode, input int nbeats);
    int idx = 0;
    int cyc = 0;
    int tail = 0;
    int fd = 0;
    int stall_left = 10;
    bit pend = 1'b0;
    logic [3:0] pdata = '0;
    @(negedge clk);
    start_i = 1'b1;
    shift_i = 4'(s);
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    check("start_busy", int'(busy_o), 1);
    check("start_out_valid", int'(out_valid_o), 0);
    got_q.delete();
    while (cyc < BUDGET) begin
      in_valid_i = (idx < nbeats) && (mode != 1 || $urandom_range(0, 4) != 0);
      in_data_i = (idx < NB) ? beats[idx] : 16'd0;
      out_ready_i = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 2 && out_valid_o && stall_left > 0) begin
        out_ready_i = 1'b0;
        stall_left--;
      end
      #1;
      if (pend) begin
        check("hold_valid", int'(out_valid_o), 1);
        check("hold_data", int'(out_data_o), int'(pdata));
      end
      if (out_valid_o && !out_ready_i) check("stall_in_ready", int'(in_ready_o), 0);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_out: got output %0d, expected none", out_data_o);
        end else begin
          check("out_data", int'(out_data_o), int'(exp_q.pop_front()));
        end
        got_q.push_back(out_data_o);
      end
      if (in_valid_i && in_ready_o) idx++;
      if (frame_done_o) fd++;
      pend = out_valid_o && !out_ready_i;
      pdata = out_data_o;
      if (nbeats < NB && idx == nbeats) break;
      if (idx == NB && exp_q.size() == 0) tail++;
      if (tail > 4) break;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= BUDGET) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d beats %0d outputs, expected %0d beats", idx, got_q.size(), nbeats);
    end
    if (nbeats == NB) begin
      in_valid_i = 1'b0;
      check("n_out", got_q.size(), NO);
      check("frame_done_cnt", fd, 1);
      check("idle_busy", int'(busy_o), 0);
      check("idle_in_ready", int'(in_ready_o), 0);
    end
  endtask

  initial begin
    vec_t vecs [12];
    vecs[0]  = '{0, 3, 3};
    vecs[1]  = '{0, -100, 0};
    vecs[2]  = '{4, 1000, 15};
    vecs[3]  = '{2, 6, RND ? 2 : 1};
    vecs[4]  = '{0, 15, 15};
    vecs[5]  = '{0, 16, 15};
    vecs[6]  = '{3, 120, 15};
    vecs[7]  = '{3, 119, RND ? 15 : 14};
    vecs[8]  = '{15, 32767, RND ? 1 : 0};
    vecs[9]  = '{0, -1, 0};
    vecs[10] = '{1, 31, 15};
    vecs[11] = '{1, 29, RND ? 15 : 14};

    rst_n = 1'b0;
    start_i = 1'b0;
    shift_i = 4'd0;
    in_valid_i = 1'b1;
    in_data_i = 16'd5;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready_o), 0);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_frame_done", int'(frame_done_o), 0);
    check("rst_out_data", int'(out_data_o), 0);
    repeat (4) @(negedge clk);
    check("idle_ignore_in", int'(in_ready_o), 0);
    check("idle_no_out", int'(out_valid_o), 0);
    in_valid_i = 1'b0;

    // uniform planes (T1, T2, T3, T7 and saturation / rounding edges)
    for (int i = 0; i < 12; i++) begin
      for (int p = 0; p < NB; p++) beats[p] = 16'(vecs[i].val);
      exp_q.delete();
      repeat (NO) exp_q.push_back(4'(vecs[i].exp));
      run_plane(vecs[i].shift, i % 2, NB);
    end

    // T4: one 2x2 block with a known max, plus markers in neighbouring blocks
    for (int p = 0; p < NB; p++) beats[p] = 16'd0;
    beats[0] = 16'd1;
    beats[1] = 16'd7;
    beats[W] = 16'd5;
    beats[W + 1] = 16'd2;
    beats[2] = 16'd9;
    beats[2 * W] = 16'd4;
    fill_model(0);
    run_plane(0, 1, NB);
    check("t4_first", int'(got_q[0]), 7);
    check("t4_second", int'(got_q[1]), 9);
    check("t4_row2_first", int'(got_q[W / 2]), 4);

    // T5: back-pressure at the first output
    rand_beats(-200, 300);
    fill_model(3);
    run_plane(3, 2, NB);

    // T6: abort after 100 beats, then a full new plane
    rand_beats(-300, 500);
    fill_model(2);
    run_plane(2, 1, 100);
    rand_beats(-1000, 2000);
    fill_model(5);
    run_plane(5, 1, NB);

    // extra random planes
    for (int k = 0; k < 2; k++) begin
      int s;
      s = $urandom_range(0, 7);
      rand_beats(-500, 3000);
      fill_model(s);
      run_plane(s, 1, NB);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
